// File: rtl/image_loader.sv
// -----------------------------------------------------------------------------
// image_loader
//
// Input-side loader for the downsampling processor. It takes the source image
// as a valid/ready byte stream and writes it into the processor data RAM. The
// bytes go to consecutive addresses that start at BASE_ADDR. When the last
// byte has been written, the loader pulses done for one cycle. It runs before
// the processor is started.
//
// State machine: IDLE -> LOAD -> FLUSH -> DONE -> IDLE
//
// Parameters
//   IMG_W      image width in pixels
//   IMG_H      image height in pixels
//   ADDR_W     RAM address width (BASE_ADDR + IMG_W*IMG_H must fit)
//   BASE_ADDR  RAM address of pixel (0,0)
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        one-cycle request to begin a load (IDLE only)
//   in_data_i      pixel byte
//   in_valid_i     in_data_i valid
//   in_ready_o     loader accepts a byte this cycle (LOAD only)
//   dram_wren_o    RAM write enable, one cycle after each handshake
//   dram_addr_o    RAM write address
//   dram_data_o    RAM write data
//   busy_o         load in progress (LOAD or FLUSH)
//   done_o         one-cycle pulse after the last RAM write
//   pixel_count_o  bytes accepted in the current/last load
//   checksum_o     (LOADER_CHECKSUM_EN only) mod-2^16 sum of accepted bytes
//
// Optional feature macro: LOADER_CHECKSUM_EN
// -----------------------------------------------------------------------------
module image_loader #(
    parameter int unsigned IMG_W     = 16,
    parameter int unsigned IMG_H     = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              dram_wren_o,
    output logic [ADDR_W-1:0] dram_addr_o,
    output logic [7:0]        dram_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       pixel_count_o
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum_o
`endif
);

    localparam int unsigned NPIX = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       pix_q, pix_d;
    logic [15:0]       col_q, col_d;
    logic [15:0]       row_q, row_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [ADDR_W-1:0] lin_addr;

    // The row/col form gives the same result as BASE_ADDR + index. The sum is
    // truncated to the RAM address width.
    assign lin_addr = ADDR_W'(BASE_ADDR + row_q * IMG_W + col_q);

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
    assign checksum_o = csum_q;
`endif

    assign dram_wren_o   = wren_q;
    assign dram_addr_o   = addr_q;
    assign dram_data_o   = data_q;
    assign pixel_count_o = pix_q;

    // State register and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            pix_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            col_q   <= col_d;
            row_q   <= row_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        col_d      = col_q;
        row_d      = row_q;
        wren_d     = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        in_ready_o = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    pix_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LOAD: begin
                busy_o     = 1'b1;
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    // The write goes onto the RAM bus one cycle after the handshake.
                    wren_d = 1'b1;
                    addr_d = lin_addr;
                    data_d = in_data_i;
                    pix_d  = pix_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q + 16'(in_data_i);
`endif
                    if (col_q == 16'(IMG_W - 1)) begin
                        col_d = '0;
                        row_d = row_q + 16'd1;
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                    if (pix_q == 16'(NPIX - 1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // The final write is on the bus during this cycle.
                busy_o  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_image_loader.sv
// -----------------------------------------------------------------------------
// tb_image_loader
//
// Directed bench for image_loader with two instances:
//   u_a : 4x4 image, BASE_ADDR 0x20
//   u_b : 3x2 image, BASE_ADDR 0 (row wrap)
//
// A negedge monitor logs RAM writes, handshakes and done pulses, each with its
// cycle number. The load checks compare those logs with hand-computed
// expected values.
// -----------------------------------------------------------------------------
module tb_image_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // Instance A signals
    logic        a_start = 1'b0, a_valid = 1'b0;
    logic [7:0]  a_data = 8'h00;
    logic        a_ready, a_wren, a_busy, a_done;
    logic [15:0] a_addr, a_pcount;
    logic [7:0]  a_dout;

    // Instance B signals
    logic        b_start = 1'b0, b_valid = 1'b0;
    logic [7:0]  b_data = 8'h00;
    logic        b_ready, b_wren, b_busy, b_done;
    logic [15:0] b_addr, b_pcount;
    logic [7:0]  b_dout;

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] a_csum, b_csum;
`endif

    image_loader #(.IMG_W(4), .IMG_H(4), .ADDR_W(16), .BASE_ADDR(32'h20)) u_a (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (a_start),
        .in_data_i    (a_data),
        .in_valid_i   (a_valid),
        .in_ready_o   (a_ready),
        .dram_wren_o  (a_wren),
        .dram_addr_o  (a_addr),
        .dram_data_o  (a_dout),
        .busy_o       (a_busy),
        .done_o       (a_done),
        .pixel_count_o(a_pcount)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum_o   (a_csum)
`endif
    );

    image_loader #(.IMG_W(3), .IMG_H(2), .ADDR_W(16), .BASE_ADDR(0)) u_b (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (b_start),
        .in_data_i    (b_data),
        .in_valid_i   (b_valid),
        .in_ready_o   (b_ready),
        .dram_wren_o  (b_wren),
        .dram_addr_o  (b_addr),
        .dram_data_o  (b_dout),
        .busy_o       (b_busy),
        .done_o       (b_done),
        .pixel_count_o(b_pcount)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum_o   (b_csum)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int a_wa[$], a_wd[$], a_wc[$], a_hc[$], a_dc[$];
    int b_wa[$], b_dc[$];
    logic [7:0] exp_data [16];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (a_wren) begin
            a_wa.push_back(int'(a_addr));
            a_wd.push_back(int'(a_dout));
            a_wc.push_back(cyc);
        end
        if (a_valid && a_ready) a_hc.push_back(cyc);
        if (a_done) a_dc.push_back(cyc);
        if (b_wren) b_wa.push_back(int'(b_addr));
        if (b_done) b_dc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        a_wa.delete(); a_wd.delete(); a_wc.delete(); a_hc.delete(); a_dc.delete();
        b_wa.delete(); b_dc.delete();
    endtask

    task automatic pulse_start(input bit which);
        if (which) b_start = 1'b1; else a_start = 1'b1;
        step();
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    // Presents one byte, waits (bounded) for ready, then completes the handshake.
    task automatic send(input bit which, input logic [7:0] v, input bit gap);
        int t = 0;
        if (which) begin b_valid = 1'b1; b_data = v; end
        else       begin a_valid = 1'b1; a_data = v; end
        while (((which ? b_ready : a_ready) == 1'b0) && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) check("ready_timeout", 32'd0, 32'd1);
        step();
        if (gap) begin
            if (which) b_valid = 1'b0; else a_valid = 1'b0;
            step();
        end
    endtask

    task automatic wait_done(input bit which);
        int t = 0;
        while (((which ? b_dc.size() : a_dc.size()) == 0) && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) check("done_timeout", 32'd0, 32'd1);
        step();
    endtask

    task automatic verify_a(input string tag);
        check({tag, "_nwr"}, a_wa.size(), 32'd16);
        check({tag, "_ndone"}, a_dc.size(), 32'd1);
        for (int i = 0; i < 16 && i < a_wa.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), a_wa[i], 32'h20 + i);
            check($sformatf("%s_data%0d", tag, i), a_wd[i], {24'd0, exp_data[i]});
            if (i < a_hc.size())
                check($sformatf("%s_lat%0d", tag, i), a_wc[i] - a_hc[i], 32'd1);
        end
        if (a_dc.size() > 0 && a_hc.size() > 0)
            check({tag, "_done_lat"}, a_dc[0] - a_hc[a_hc.size() - 1], 32'd2);
        check({tag, "_pcount"}, a_pcount, 32'd16);
        check({tag, "_busy"}, a_busy, 32'd0);
    endtask

    initial begin
        // Reset state
        step();
        check("rst_ready", a_ready, 0);
        check("rst_wren", a_wren, 0);
        check("rst_addr", a_addr, 0);
        check("rst_data", a_dout, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_pcount", a_pcount, 0);
        rst_n = 1'b1;
        step();

        // Reset in the middle of a load
        pulse_start(1'b0);
        for (int i = 0; i < 5; i++) send(1'b0, 8'(8'hA0 + i), 1'b0);
        check("mid_pcount", a_pcount, 5);
        check("mid_wren", a_wren, 1);
        rst_n = 1'b0;
        #1;
        check("arst_wren", a_wren, 0);
        check("arst_busy", a_busy, 0);
        check("arst_ready", a_ready, 0);
        check("arst_pcount", a_pcount, 0);
        check("arst_addr", a_addr, 0);
        clear_logs();
        step();
        rst_n = 1'b1;
        repeat (5) step();
        check("post_rst_nwr", a_wa.size(), 0);
        check("post_rst_ready", a_ready, 0);
        a_valid = 1'b0;

        // Full load, back-to-back bytes
        clear_logs();
        for (int i = 0; i < 16; i++) exp_data[i] = 8'(i);
        pulse_start(1'b0);
        for (int i = 0; i < 16; i++) send(1'b0, 8'(i), 1'b0);
        a_valid = 1'b0;
        wait_done(1'b0);
        repeat (3) step();
        verify_a("full");
        check("hold_pcount", a_pcount, 16);

        // Stalled stream: valid toggles every cycle
        clear_logs();
        pulse_start(1'b0);
        for (int i = 0; i < 16; i++) send(1'b0, 8'(i), 1'b1);
        wait_done(1'b0);
        repeat (3) step();
        verify_a("stall");

        // in_valid in IDLE is ignored
        clear_logs();
        a_valid = 1'b1;
        a_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("idle_ready%0d", i), a_ready, 0);
            step();
        end
        a_valid = 1'b0;
        step();
        check("idle_nwr", a_wa.size(), 0);

        // start pulsed mid-load is ignored
        clear_logs();
        pulse_start(1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 7) a_start = 1'b1;
            send(1'b0, 8'(i), 1'b0);
            a_start = 1'b0;
            if (i == 7) check("restart_pc8", a_pcount, 8);
            if (i == 8) check("restart_pc9", a_pcount, 9);
        end
        a_valid = 1'b0;
        wait_done(1'b0);
        repeat (3) step();
        verify_a("restart");

`ifdef LOADER_CHECKSUM_EN
        // Checksum over 16 bytes of 0xFF
        clear_logs();
        for (int i = 0; i < 16; i++) exp_data[i] = 8'hFF;
        pulse_start(1'b0);
        for (int i = 0; i < 16; i++) send(1'b0, 8'hFF, 1'b0);
        a_valid = 1'b0;
        wait_done(1'b0);
        check("csum_done", a_csum, 32'h0FF0);
        repeat (3) step();
        verify_a("csum");
        check("csum_hold", a_csum, 32'h0FF0);
        pulse_start(1'b0);
        check("csum_clear", a_csum, 0);
        check("csum_pc_clear", a_pcount, 0);
        send(1'b0, 8'h12, 1'b0);
        check("csum_first", a_csum, 32'h12);
        rst_n = 1'b0;
        #1;
        check("csum_rst", a_csum, 0);
        step();
        rst_n = 1'b1;
        a_valid = 1'b0;
        step();
`endif

        // Row wrap on the 3x2 instance, two loads
        for (int pass = 0; pass < 2; pass++) begin
            clear_logs();
            pulse_start(1'b1);
            for (int i = 0; i < 6; i++) send(1'b1, 8'(8'h40 + i), 1'b0);
            b_valid = 1'b0;
            wait_done(1'b1);
            repeat (3) step();
            check($sformatf("wrap%0d_nwr", pass), b_wa.size(), 6);
            check($sformatf("wrap%0d_ndone", pass), b_dc.size(), 1);
            for (int i = 0; i < 6 && i < b_wa.size(); i++)
                check($sformatf("wrap%0d_addr%0d", pass, i), b_wa[i], i);
            check($sformatf("wrap%0d_pcount", pass), b_pcount, 6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
